// File: rtl/si_dac_driver_if.sv
// Sample handshake between the sine-sample source and the DAC frame driver.
//   din       : N-bit sample word, MSB shifted first
//   din_valid : source holds a valid sample on din
//   din_ready : driver holding buffer is empty
// master = sample source, slave = si_dac_driver.
interface si_dac_driver_if #(
  parameter int N = 12
);
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/si_dac_driver.sv
// Parallel-to-serial frame generator for the 12-bit serial DAC stage.
// Buffers one sample, shifts it out MSB-first with SI_en high for N cycles,
// then pulses soc for one cycle, then idles GAP cycles before the next frame.
//   clk, rst_n : clock and synchronous active-low reset
//   in_if      : sample handshake (slave side); din_ready = holding buffer empty
//   SI, SI_en  : serial data and shift enable to the DAC
//   soc        : one-cycle start-of-conversion pulse per frame
//   busy       : frame in progress (SHIFT, SOC or GAP)
//   frame_cnt  : number of soc pulses issued, wraps modulo 2^CNT_W
module si_dac_driver #(
  parameter int N     = 12,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  si_dac_driver_if.slave   in_if,
  output logic             SI,
  output logic             SI_en,
  output logic             soc,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int CMAX = (N > GAP) ? N : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SOC, S_GAP} state_t;

  state_t           state_q;
  logic [N-1:0]     buf_q;
  logic             buf_full_q;
  logic [N-1:0]     shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             si_en_q;
  logic             soc_q;
  logic             busy_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic accept;
  logic reload;

  assign in_if.din_ready = ~buf_full_q;
  assign accept          = in_if.din_valid & ~buf_full_q;

  // Reload decision points: idle, end of SOC when there is no gap, last GAP cycle.
  assign reload = buf_full_q &
                  ((state_q == S_IDLE) ||
                   ((state_q == S_SOC) && (GAP == 0)) ||
                   ((state_q == S_GAP) && (cnt_q == '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_full_q  <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      si_en_q     <= 1'b0;
      soc_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (accept) begin
        buf_q      <= in_if.din;
        buf_full_q <= 1'b1;
      end

      if (reload) begin
        state_q    <= S_SHIFT;
        shreg_q    <= buf_q;
        cnt_q      <= CW'(N - 1);
        si_en_q    <= 1'b1;
        soc_q      <= 1'b0;
        busy_q     <= 1'b1;
        buf_full_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SHIFT: begin
            // Zeros shift in, so SI is already 0 by the time SOC is reached.
            shreg_q <= shreg_q << 1;
            if (cnt_q == '0) begin
              state_q     <= S_SOC;
              si_en_q     <= 1'b0;
              soc_q       <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_SOC: begin
            soc_q <= 1'b0;
            if (GAP > 0) begin
              state_q <= S_GAP;
              cnt_q   <= CW'(GAP - 1);
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_GAP: begin
            if (cnt_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign SI        = shreg_q[N-1];
  assign SI_en     = si_en_q;
  assign soc       = soc_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_si_dac_driver.sv
// Bench for si_dac_driver: three builds (defaults, GAP=0, CNT_W=4) checked
// every cycle against a frame-position model, plus directed sequences.
module tb_si_dac_driver;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] din_s [3];
  logic         vld_s [3];
  logic         si_w [3], sien_w [3], soc_w [3], busy_w [3], rdy_w [3];
  logic [15:0]  fc0, fc1;
  logic [3:0]   fc2;

  si_dac_driver_if #(.N(N)) if_a ();
  si_dac_driver_if #(.N(N)) if_b ();
  si_dac_driver_if #(.N(N)) if_c ();

  assign if_a.din = din_s[0];  assign if_a.din_valid = vld_s[0];  assign rdy_w[0] = if_a.din_ready;
  assign if_b.din = din_s[1];  assign if_b.din_valid = vld_s[1];  assign rdy_w[1] = if_b.din_ready;
  assign if_c.din = din_s[2];  assign if_c.din_valid = vld_s[2];  assign rdy_w[2] = if_c.din_ready;

  si_dac_driver #(.N(N), .GAP(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_if(if_a.slave), .SI(si_w[0]), .SI_en(sien_w[0]),
    .soc(soc_w[0]), .busy(busy_w[0]), .frame_cnt(fc0));
  si_dac_driver #(.N(N), .GAP(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_if(if_b.slave), .SI(si_w[1]), .SI_en(sien_w[1]),
    .soc(soc_w[1]), .busy(busy_w[1]), .frame_cnt(fc1));
  si_dac_driver #(.N(N), .GAP(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_if(if_c.slave), .SI(si_w[2]), .SI_en(sien_w[2]),
    .soc(soc_w[2]), .busy(busy_w[2]), .frame_cnt(fc2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: frame position pos (-1 idle, 0..N-1 bit index, N soc, N+1..N+GAP gap).
  typedef struct {
    int           pos;
    bit           full;
    logic [N-1:0] bufw;
    logic [N-1:0] word;
    int unsigned  cnt;
  } ms_t;

  ms_t ms [3];
  int  gapk [3] = '{2, 0, 2};
  int  cwk  [3] = '{16, 16, 4};

  function automatic ms_t step(input ms_t s, input logic rn, input logic v,
                               input logic [N-1:0] d, input int gap, input int cw);
    ms_t r;
    r = s;
    if (!rn) begin
      r.pos = -1; r.full = 1'b0; r.cnt = 0;
      return r;
    end
    if (s.pos == -1 || s.pos == N + gap) begin
      if (s.full) begin
        r.pos = 0; r.word = s.bufw; r.full = 1'b0;
      end else begin
        r.pos = -1;
      end
    end else begin
      r.pos = s.pos + 1;
      if (r.pos == N) r.cnt = (s.cnt + 1) % (1 << cw);
    end
    if (v && !s.full) begin
      r.bufw = d; r.full = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      ms[k] = step(ms[k], rst_n, vld_s[k], din_s[k], gapk[k], cwk[k]);

  // Monitor: per-cycle model comparison, soc bookkeeping, downstream deserializer.
  bit           chk_en = 1'b0;
  int           cyc = 0;
  int           nsoc [3] = '{0, 0, 0};
  int           socA[$], socB[$];
  logic [N-1:0] pdqA[$];
  logic         aftB[$];
  logic [N-1:0] shA = '0;
  bit           socb_prev = 1'b0;

  always @(negedge clk) begin
    logic [15:0] fcv [3];
    int          p;
    logic        e_en;
    cyc++;
    fcv[0] = fc0; fcv[1] = fc1; fcv[2] = {12'b0, fc2};
    if (sien_w[0] === 1'b1) shA = {shA[N-2:0], si_w[0]};
    if (soc_w[0] === 1'b1) begin socA.push_back(cyc); pdqA.push_back(shA); end
    if (socb_prev) aftB.push_back(sien_w[1]);
    socb_prev = (soc_w[1] === 1'b1);
    if (soc_w[1] === 1'b1) socB.push_back(cyc);
    for (int k = 0; k < 3; k++) begin
      if (soc_w[k] === 1'b1) nsoc[k]++;
      if (chk_en) begin
        p    = ms[k].pos;
        e_en = (p >= 0 && p < N);
        cmp($sformatf("d%0d_SI_en@%0d", k, cyc), sien_w[k], e_en);
        cmp($sformatf("d%0d_SI@%0d", k, cyc), si_w[k], e_en ? ms[k].word[N-1-p] : 1'b0);
        cmp($sformatf("d%0d_soc@%0d", k, cyc), soc_w[k], p == N);
        cmp($sformatf("d%0d_busy@%0d", k, cyc), busy_w[k], p >= 0);
        cmp($sformatf("d%0d_ready@%0d", k, cyc), rdy_w[k], !ms[k].full);
        cmp($sformatf("d%0d_fcnt@%0d", k, cyc), fcv[k], ms[k].cnt);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int k, input logic [N-1:0] w);
    int i = 0;
    din_s[k] = w;
    vld_s[k] = 1'b1;
    while (rdy_w[k] !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (rdy_w[k] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout d%0d actual=%0d required=%0d", k, 0, 1);
      vld_s[k] = 1'b0;
      return;
    end
    @(negedge clk);
    vld_s[k] = 1'b0;
  endtask

  task automatic wait_socs(input int k, input int target, input int budget);
    int i = 0;
    while (nsoc[k] < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (nsoc[k] < target) begin
      n_cmp++; n_bad++;
      $display("FAIL soc_timeout d%0d actual=%0d required=%0d", k, nsoc[k], target);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] pdata;
    int           ones;
  } vec_t;

  initial begin
    vec_t         tab [6];
    logic [N-1:0] bits;
    int           base, fc_exp, pcnt;
    bit           pend [3];

    tab[0] = '{12'h001, 12'h001, 1};
    tab[1] = '{12'h555, 12'h555, 6};
    tab[2] = '{12'h3C7, 12'h3C7, 7};
    tab[3] = '{12'hFFE, 12'hFFE, 11};
    tab[4] = '{12'h800, 12'h800, 1};
    tab[5] = '{12'h0F0, 12'h0F0, 4};

    for (int k = 0; k < 3; k++) begin
      din_s[k] = '0; vld_s[k] = 1'b0; pend[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("rst_SI_d%0d", k), si_w[k], 1'b0);
      cmp($sformatf("rst_SI_en_d%0d", k), sien_w[k], 1'b0);
      cmp($sformatf("rst_soc_d%0d", k), soc_w[k], 1'b0);
      cmp($sformatf("rst_busy_d%0d", k), busy_w[k], 1'b0);
      cmp($sformatf("rst_ready_d%0d", k), rdy_w[k], 1'b1);
    end
    cmp("rst_fcnt_a", fc0, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Single word 0xA5C: ready low for one cycle, bit pattern, soc, gap.
    bits = 12'hA5C;
    send(0, 12'hA5C);
    cmp("seq1_ready_low", rdy_w[0], 1'b0);
    @(negedge clk);
    cmp("seq1_ready_back", rdy_w[0], 1'b1);
    for (int i = 0; i < N; i++) begin
      cmp($sformatf("seq1_SI_en_%0d", i), sien_w[0], 1'b1);
      cmp($sformatf("seq1_SI_%0d", i), si_w[0], bits[N-1-i]);
      @(negedge clk);
    end
    cmp("seq1_soc", soc_w[0], 1'b1);
    cmp("seq1_SI_en_at_soc", sien_w[0], 1'b0);
    cmp("seq1_fcnt", fc0, 1);
    repeat (2) @(negedge clk);
    cmp("seq1_busy_in_gap", busy_w[0], 1'b1);
    @(negedge clk);
    cmp("seq1_busy_after_gap", busy_w[0], 1'b0);
    cmp("seq1_pdata", pdqA[pdqA.size()-1], 12'hA5C);
    fc_exp = 1;

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      base = nsoc[0];
      send(0, tab[i].din);
      wait_socs(0, base + 1, 40);
      fc_exp++;
      cmp($sformatf("tab%0d_pdata", i), pdqA[base], tab[i].pdata);
      cmp($sformatf("tab%0d_ones", i), $countones(pdqA[base]), tab[i].ones);
      cmp($sformatf("tab%0d_fcnt", i), fc0, fc_exp);
    end
    repeat (5) @(negedge clk);

    // Back-to-back with backpressure on the third word.
    base = nsoc[0];
    send(0, 12'h000);
    send(0, 12'hFFF);
    send(0, 12'h800);
    wait_socs(0, base + 3, 120);
    fc_exp += 3;
    cmp("b2b_period1", socA[base+1] - socA[base], 15);
    cmp("b2b_period2", socA[base+2] - socA[base+1], 15);
    cmp("b2b_w0", pdqA[base], 12'h000);
    cmp("b2b_w1", pdqA[base+1], 12'hFFF);
    cmp("b2b_w2", pdqA[base+2], 12'h800);
    cmp("b2b_fcnt", fc0, fc_exp);

    // GAP=0 build: soc 13 apart, SI_en right after soc.
    base = nsoc[1];
    send(1, 12'h123);
    send(1, 12'h456);
    wait_socs(1, base + 2, 80);
    cmp("gap0_period", socB[base+1] - socB[base], 13);
    cmp("gap0_reassert", aftB[base], 1'b1);

    // CNT_W=4 build: 17 frames wrap to 1.
    for (int i = 0; i < 17; i++) send(2, N'(i * 37));
    wait_socs(2, 17, 400);
    cmp("wrap_fcnt", fc2, 4'd1);
    repeat (5) @(negedge clk);

    // Reset five cycles into SHIFT with a second word buffered.
    send(0, 12'h6B2);
    @(negedge clk);
    send(0, 12'h1D4);
    repeat (3) @(negedge clk);
    cmp("mid_pre_SI_en", sien_w[0], 1'b1);
    cmp("mid_pre_ready", rdy_w[0], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("mid_SI", si_w[0], 1'b0);
    cmp("mid_SI_en", sien_w[0], 1'b0);
    cmp("mid_soc", soc_w[0], 1'b0);
    cmp("mid_busy", busy_w[0], 1'b0);
    cmp("mid_fcnt", fc0, 0);
    cmp("mid_ready", rdy_w[0], 1'b1);
    rst_n = 1'b1;
    base = nsoc[0];
    pcnt = pdqA.size();
    repeat (3) @(negedge clk);
    cmp("mid_no_restart", busy_w[0], 1'b0);
    repeat (37) @(negedge clk);
    cmp("mid_no_soc", nsoc[0], base);
    cmp("mid_no_pdata", pdqA.size(), pcnt);

    // Randomized traffic on all builds, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 3; k++) begin
        if (pend[k] || !vld_s[k]) begin
          vld_s[k] = ($urandom_range(0, 3) != 0);
          din_s[k] = N'($urandom);
        end
        pend[k] = vld_s[k] && rdy_w[k] && rst_n;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) vld_s[k] = 1'b0;
    repeat (60) @(negedge clk);
    for (int k = 0; k < 3; k++)
      cmp($sformatf("drain_busy_d%0d", k), busy_w[k], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d required=%0d", cyc, 0);
    $fatal(1, "watchdog");
  end

endmodule
